// File: rtl/flash_word_reader_if.sv
// flash_word_reader_if: bundles the CPU-side word-read bus and the flash-controller halfword
// handshake used by flash_word_reader.
//   req_i/addr_i        word read request and byte address from the bus/MMU stage
//   data_o/ack_o/err_o  word response, one-cycle ack, one-cycle timeout error
//   busy_o              reader not idle
//   fl_req_o/fl_addr_o  halfword read request and halfword address to the flash controller
//   fl_data_i/fl_done_i halfword data and completion from the flash controller
// The slave modport is the reader's view; the master modport is the view of whatever drives
// the requests and models the controller.
interface flash_word_reader_if;
  logic        req_i;
  logic [22:0] addr_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        err_o;
  logic        busy_o;
  logic        fl_req_o;
  logic [21:0] fl_addr_o;
  logic [15:0] fl_data_i;
  logic        fl_done_i;

  modport slave (
    input  req_i, addr_i, fl_data_i, fl_done_i,
    output data_o, ack_o, err_o, busy_o, fl_req_o, fl_addr_o
  );

  modport master (
    output req_i, addr_i, fl_data_i, fl_done_i,
    input  data_o, ack_o, err_o, busy_o, fl_req_o, fl_addr_o
  );
endinterface

// File: rtl/flash_word_reader.sv
// flash_word_reader: turns a 32-bit word read into two sequential 16-bit halfword reads on the
// flash controller req/done handshake, assembles them little-endian and returns the word with
// a one-cycle ack. Each halfword wait is bounded by TIMEOUT_CYCLES (0 disables the timeout);
// a timeout answers with err_o and 32'hFFFF_FFFF.
// Optional feature: define FLASH_WORD_CACHE_EN for a one-entry word cache (1-cycle hits).
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  flash_word_reader_if.slave (CPU request/response and flash halfword handshake)
module flash_word_reader #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                  clk,
  input logic                  rst,
  flash_word_reader_if.slave   bus
);

  // Counter only ever needs to hold TIMEOUT_CYCLES-1.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StRdLo, StGap, StRdHi, StResp} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [20:0]       r_addr;
  logic [15:0]       r_lo;
  logic [31:0]       r_data;
  logic              r_err;
  logic [CntW-1:0]   r_cnt;
  logic              w_rd_state;
  logic              w_tmo;
  logic              w_hit;
  logic [31:0]       w_hit_word;
  logic              w_unused_addr;

  assign w_unused_addr = ^bus.addr_i[1:0];

  assign w_rd_state = (r_state == StRdLo) || (r_state == StRdHi);

  // Fires on the cycle the wait would reach TIMEOUT_CYCLES; a coincident done wins.
  assign w_tmo = (TIMEOUT_CYCLES != 0) && w_rd_state && !bus.fl_done_i &&
                 (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

`ifdef FLASH_WORD_CACHE_EN
  logic        r_c_valid;
  logic [20:0] r_c_tag;
  logic [31:0] r_c_word;

  // Filled only by a successful high-halfword completion; errors never reach this path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c_valid <= 1'b0;
      r_c_tag   <= '0;
      r_c_word  <= '0;
    end else if (r_state == StRdHi && bus.fl_done_i) begin
      r_c_valid <= 1'b1;
      r_c_tag   <= r_addr;
      r_c_word  <= {bus.fl_data_i, r_lo};
    end
  end

  assign w_hit      = r_c_valid && (r_c_tag == bus.addr_i[22:2]);
  assign w_hit_word = r_c_word;
`else
  assign w_hit      = 1'b0;
  assign w_hit_word = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (bus.req_i) begin
          w_state_next = w_hit ? StResp : StRdLo;
        end
      end
      StRdLo: begin
        if (bus.fl_done_i) begin
          w_state_next = StGap;
        end else if (w_tmo) begin
          w_state_next = StResp;
        end
      end
      StGap:  w_state_next = StRdHi;
      StRdHi: begin
        if (bus.fl_done_i || w_tmo) begin
          w_state_next = StResp;
        end
      end
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.fl_req_o  = w_rd_state;
    bus.fl_addr_o = {r_addr, r_state == StRdHi};
    bus.busy_o    = (r_state != StIdle);
    bus.ack_o     = (r_state == StResp);
    bus.err_o     = (r_state == StResp) && r_err;
    bus.data_o    = r_data;
  end

  // Datapath: address latch, halfword capture, response word and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_lo   <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      // Held at zero outside the read states so every read state starts from zero.
      r_cnt <= w_rd_state ? r_cnt + CntW'(1) : '0;
      case (r_state)
        StIdle: begin
          if (bus.req_i) begin
            r_addr <= bus.addr_i[22:2];
            if (w_hit) begin
              r_data <= w_hit_word;
              r_err  <= 1'b0;
            end
          end
        end
        StRdLo: begin
          if (bus.fl_done_i) begin
            r_lo <= bus.fl_data_i;
          end else if (w_tmo) begin
            r_data <= '1;
            r_err  <= 1'b1;
          end
        end
        StRdHi: begin
          if (bus.fl_done_i) begin
            r_data <= {bus.fl_data_i, r_lo};
            r_err  <= 1'b0;
          end else if (w_tmo) begin
            r_data <= '1;
            r_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
